uart_rx: RTL and testbench

//  UART receiver: the receive direction of uart_tx, sharing uart_pkg. Synchronises the asynchronous
//  rx line, oversamples each bit 16x and majority-votes the mid-bit samples. Reassembles LSB-first

---
 rtl/uart_rx.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 16x-oversampled UART receiver with majority vote, valid/ready
//           output register and parity / framing / overrun error pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  overrun_err_o,
  output logic                  busy_o
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int B_W = $clog2(DATA_WIDTH);

  localparam logic [S_W-1:0] S_VOTE0 = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_VOTE1 = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0] S_VOTE2 = S_W'(OVERSAMPLE / 2 + 1);
  localparam logic [S_W-1:0] S_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0] B_LAST  = B_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // Line synchroniser; resets to the idle (high) level.
  logic rx_meta_q, rxs_q, rxs_prev_q;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   baud_div_q, baud_div_d;
  logic [DIV_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
  logic [S_W-1:0]         s_q, s_d;
  logic [1:0]             samp_q, samp_d;
  logic [B_W-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   stop2_q, stop2_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   done_q, done_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_pulse_q, perr_pulse_d;
  logic                   ferr_pulse_q, ferr_pulse_d;
  logic                   ovr_pulse_q, ovr_pulse_d;

  logic tick;
  logic vote;
  logic vote_now;
  logic bit_end;
  logic ferr_now;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_i;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      baud_div_q   <= '0;
      tick_cnt_q   <= '0;
      s_q          <= '0;
      samp_q       <= 2'b11;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop2_q      <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_pulse_q <= 1'b0;
      ferr_pulse_q <= 1'b0;
      ovr_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_div_q   <= baud_div_d;
      tick_cnt_q   <= tick_cnt_d;
      s_q          <= s_d;
      samp_q       <= samp_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      stop2_q      <= stop2_d;
      par_err_q    <= par_err_d;
      frm_err_q    <= frm_err_d;
      done_q       <= done_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_pulse_q <= perr_pulse_d;
      ferr_pulse_q <= ferr_pulse_d;
      ovr_pulse_q  <= ovr_pulse_d;
    end
  end

  // Majority of the three mid-bit samples; the third is the live rxs.
  assign vote     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs_q) | (samp_q[0] & rxs_q);
  assign vote_now = tick && (s_q == S_VOTE2);
  assign bit_end  = tick && (s_q == S_LAST);
  assign ferr_now = frm_err_q | ~vote;

  always_comb begin
    state_d      = state_q;
    baud_div_d   = baud_div_q;
    tick_cnt_d   = tick_cnt_q;
    s_d          = s_q;
    samp_d       = samp_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    stop2_d      = stop2_q;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
    done_d       = 1'b0;
    data_d       = data_q;
    valid_d      = valid_q;
    perr_pulse_d = 1'b0;
    ferr_pulse_d = 1'b0;
    ovr_pulse_d  = 1'b0;
    tick         = 1'b0;

    if (state_q == ST_IDLE) begin
      tick_cnt_d = '0;
      s_d        = '0;
      baud_div_d = baud_div_i;
    end else if (tick_cnt_q == baud_div_q) begin
      tick       = 1'b1;
      tick_cnt_d = '0;
      s_d        = s_q + S_W'(1);
    end else begin
      tick_cnt_d = tick_cnt_q + DIV_WIDTH'(1);
    end

    if (tick && ((s_q == S_VOTE0) || (s_q == S_VOTE1))) begin
      samp_d = {samp_q[0], rxs_q};
    end

    case (state_q)
      ST_IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d   = ST_START;
          par_en_d  = parity_en_i;
          par_odd_d = parity_odd_i;
          stop2_d   = stop2_i;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      ST_START: begin
        if (vote_now && vote) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (vote_now) begin
          shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
        end
        if (bit_end) begin
          if (bit_idx_q == B_LAST) begin
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + B_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (vote_now) begin
          par_err_d = vote ^ (^shift_q) ^ par_odd_q;
        end
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // The frame ends at the last stop vote so the next start bit is caught early.
        if (vote_now) begin
          frm_err_d = ferr_now;
          if (!stop2_q || bit_idx_q[0]) begin
            done_d  = 1'b1;
            state_d = ferr_now ? ST_WAIT_IDLE : ST_IDLE;
          end
        end else if (bit_end) begin
          bit_idx_d = bit_idx_q + B_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done_q) begin
      if (!valid_q || ready_i) begin
        data_d       = shift_q;
        valid_d      = 1'b1;
        perr_pulse_d = par_err_q;
        ferr_pulse_d = frm_err_q;
      end else begin
        ovr_pulse_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign parity_err_o  = perr_pulse_q;
  assign frame_err_o   = ferr_pulse_q;
  assign overrun_err_o = ovr_pulse_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : directed self-checking bench for uart_rx.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_i = 1'b1;
  logic [15:0] baud_div_i = 16'd0;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        stop2_i = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        overrun_err_o;
  logic        busy_o;

  int total = 0;
  int bad = 0;

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rx_i          (rx_i),
    .baud_div_i    (baud_div_i),
    .parity_en_i   (parity_en_i),
    .parity_odd_i  (parity_odd_i),
    .stop2_i       (stop2_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o),
    .overrun_err_o (overrun_err_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Event recorder; the test tasks compare deltas of these counters.
  logic [7:0] acc_q[$];
  int n_valid_cyc = 0, n_perr = 0, n_perr_align = 0, n_ferr = 0, n_ferr_align = 0, n_ovr = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk_i) begin
    if (valid_o && ready_i) acc_q.push_back(data_o);
    if (valid_o) n_valid_cyc++;
    if (parity_err_o) n_perr++;
    if (parity_err_o && valid_o && !valid_prev) n_perr_align++;
    if (frame_err_o) n_ferr++;
    if (frame_err_o && valid_o && !valid_prev) n_ferr_align++;
    if (overrun_err_o) n_ovr++;
    valid_prev = valid_o;
  end

  task automatic drive_bit(input logic v, input int cpb);
    rx_i = v;
    repeat (cpb) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int cpb, input logic pen,
                            input logic podd, input logic s2, input logic pflip,
                            input logic stopv);
    parity_en_i  = pen;
    parity_odd_i = podd;
    stop2_i      = s2;
    drive_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive_bit(d[i], cpb);
    if (pen) drive_bit((^d) ^ podd ^ pflip, cpb);
    drive_bit(stopv, cpb);
    if (s2) drive_bit(stopv, cpb);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if ({parity_err_o, frame_err_o, overrun_err_o} !== 3'b000) begin
      bad++; $display("FAIL reset_errs got=%b exp=000", {parity_err_o, frame_err_o, overrun_err_o});
    end
  endtask

  task automatic test_basic();
    int a0 = acc_q.size(), v0 = n_valid_cyc, p0 = n_perr, f0 = n_ferr;
    baud_div_i = 16'd0;
    ready_i = 1'b1;
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk_i);
    #1;
    total++; if (acc_q.size() !== a0 + 1) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", acc_q.size() - a0, 1); end
    else begin
      total++; if (acc_q[a0] !== 8'h55) begin bad++; $display("FAIL basic_data got=%h exp=55", acc_q[a0]); end
    end
    total++; if (n_valid_cyc - v0 !== 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d exp=1", n_valid_cyc - v0); end
    total++; if ((n_perr - p0) + (n_ferr - f0) !== 0) begin bad++; $display("FAIL basic_errs got=%0d exp=0", (n_perr - p0) + (n_ferr - f0)); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy_o); end
    // 0xC4 has three ones: even-parity bit is 1, sent correctly.
    p0 = n_perr;
    send_frame(8'hC4, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk_i);
    #1;
    total++; if (data_o !== 8'hC4) begin bad++; $display("FAIL even_ok_data got=%h exp=c4", data_o); end
    total++; if (n_perr - p0 !== 0) begin bad++; $display("FAIL even_ok_perr got=%0d exp=0", n_perr - p0); end
  endtask

  task automatic test_parity();
    int p0 = n_perr, pa0 = n_perr_align, a0 = acc_q.size();
    // 0xA3 has four ones: correct even-parity bit is 0, so flip it to 1.
    send_frame(8'hA3, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (20) @(posedge clk_i);
    #1;
    total++; if (acc_q.size() !== a0 + 1) begin bad++; $display("FAIL parity_count got=%0d exp=1", acc_q.size() - a0); end
    total++; if (data_o !== 8'hA3) begin bad++; $display("FAIL parity_data got=%h exp=a3", data_o); end
    total++; if (n_perr - p0 !== 1) begin bad++; $display("FAIL parity_err_count got=%0d exp=1", n_perr - p0); end
    total++; if (n_perr_align - pa0 !== 1) begin bad++; $display("FAIL parity_err_align got=%0d exp=1", n_perr_align - pa0); end
  endtask

  task automatic test_glitch();
    int v0 = n_valid_cyc;
    rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL glitch_busy_high got=%b exp=1", busy_o); end
    repeat (30) @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL glitch_busy_low got=%b exp=0", busy_o); end
    total++; if (n_valid_cyc - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", n_valid_cyc - v0); end
  endtask

  task automatic test_break();
    int f0 = n_ferr, fa0 = n_ferr_align, a0 = acc_q.size();
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (1600) @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL break_busy_low_line got=%b exp=1", busy_o); end
    rx_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    total++; if (n_ferr - f0 !== 1) begin bad++; $display("FAIL break_ferr_count got=%0d exp=1", n_ferr - f0); end
    total++; if (n_ferr_align - fa0 !== 1) begin bad++; $display("FAIL break_ferr_align got=%0d exp=1", n_ferr_align - fa0); end
    total++; if (acc_q.size() !== a0 + 1) begin bad++; $display("FAIL break_words got=%0d exp=1", acc_q.size() - a0); end
    total++; if (data_o !== 8'h3C) begin bad++; $display("FAIL break_data got=%h exp=3c", data_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL break_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_overrun();
    int o0 = n_ovr, p0 = n_perr, f0 = n_ferr, a0 = acc_q.size();
    ready_i = 1'b0;
    send_frame(8'h11, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 32);
    send_frame(8'h22, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk_i);
    #1;
    total++; if (data_o !== 8'h11) begin bad++; $display("FAIL ovr_data_kept got=%h exp=11", data_o); end
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", valid_o); end
    total++; if (n_ovr - o0 !== 1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", n_ovr - o0); end
    total++; if ((n_perr - p0) + (n_ferr - f0) !== 0) begin bad++; $display("FAIL ovr_other_errs got=%0d exp=0", (n_perr - p0) + (n_ferr - f0)); end
    ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL ovr_valid_clear got=%b exp=0", valid_o); end
    total++; if (acc_q.size() !== a0 + 1) begin bad++; $display("FAIL ovr_accepted got=%0d exp=1", acc_q.size() - a0); end
    else begin
      total++; if (acc_q[a0] !== 8'h11) begin bad++; $display("FAIL ovr_accepted_data got=%h exp=11", acc_q[a0]); end
    end
  endtask

  task automatic test_back_to_back();
    int a0 = acc_q.size(), p0 = n_perr, f0 = n_ferr;
    baud_div_i = 16'd3;
    ready_i = 1'b1;
    drive_bit(1'b1, 128);
    // 8O2: both 0x00 and 0xFF take parity bit 1; slow then fast bit period.
    send_frame(8'h00, 66, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 62, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) @(posedge clk_i);
    #1;
    total++; if (acc_q.size() !== a0 + 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", acc_q.size() - a0); end
    else begin
      total++; if (acc_q[a0] !== 8'h00) begin bad++; $display("FAIL b2b_word0 got=%h exp=00", acc_q[a0]); end
      total++; if (acc_q[a0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_word1 got=%h exp=ff", acc_q[a0+1]); end
    end
    total++; if ((n_perr - p0) + (n_ferr - f0) !== 0) begin bad++; $display("FAIL b2b_errs got=%0d exp=0", (n_perr - p0) + (n_ferr - f0)); end

    // Abort a frame three data bits in.
    drive_bit(1'b0, 64);
    drive_bit(1'b1, 64);
    drive_bit(1'b0, 64);
    drive_bit(1'b1, 64);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy_o); end
    rx_i = 1'b1;
    rst_i = 1'b1;
    #2;
    total++; if ({valid_o, busy_o, parity_err_o, frame_err_o, overrun_err_o} !== 5'b00000) begin
      bad++; $display("FAIL rst_mid_flags got=%b exp=00000", {valid_o, busy_o, parity_err_o, frame_err_o, overrun_err_o});
    end
    total++; if (data_o !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h exp=00", data_o); end
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    a0 = acc_q.size();
    p0 = n_perr;
    drive_bit(1'b1, 128);
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%b exp=0", busy_o); end
    // 0x96 has four ones: odd-parity bit is 1.
    send_frame(8'h96, 64, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) @(posedge clk_i);
    #1;
    total++; if (acc_q.size() !== a0 + 1) begin bad++; $display("FAIL post_rst_count got=%0d exp=1", acc_q.size() - a0); end
    else begin
      total++; if (acc_q[a0] !== 8'h96) begin bad++; $display("FAIL post_rst_data got=%h exp=96", acc_q[a0]); end
    end
    total++; if (n_perr - p0 !== 0) begin bad++; $display("FAIL post_rst_perr got=%0d exp=0", n_perr - p0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
